// File: rtl/sprockell_shmem_pkg.sv
// Shared types and constants for the Sprockell shared data memory.
package sprockell_shmem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_TAS   = 2'b11
  } cmd_e;

  localparam int DEF_NCORES = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DELAY  = 2;

  // Reply record is sized for up to 8 cores and core-register-wide data.
  localparam int CORE_IDX_W = 3;
  localparam int REP_DATA_W = DEF_DATA_W;

  typedef struct packed {
    logic                  valid;
    logic [CORE_IDX_W-1:0] core;
    logic [REP_DATA_W-1:0] data;
  } rep_entry_t;

endpackage

// File: rtl/shmem_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module shmem_rr_arbiter #(
  parameter  int NCORES = 4,
  localparam int IDX_W  = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  output logic [NCORES-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NCORES; i++) begin
      cand = int'(last_grant_i) + i;
      if (cand >= NCORES) cand = cand - NCORES;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sprockell_shared_mem.sv
// Shared data memory for several Sprockell cores: per-core request slot, round-robin
// grant, fixed-latency reply pipeline. SPROCKELL_SHMEM_TESTSET_EN enables atomic test-and-set.
module sprockell_shared_mem
  import sprockell_shmem_pkg::*;
#(
  parameter int NCORES = DEF_NCORES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DELAY  = DEF_DELAY
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic [2*NCORES-1:0]      req_cmd_i,
  input  logic [ADDR_W*NCORES-1:0] req_addr_i,
  input  logic [DATA_W*NCORES-1:0] req_data_i,
  output logic [NCORES-1:0]        req_ready_o,
  output logic [NCORES-1:0]        rep_valid_o,
  output logic [DATA_W*NCORES-1:0] rep_data_o
);

  localparam int IDX_W = $clog2(NCORES);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NCORES-1:0] slot_full_q, slot_full_d;
  cmd_e              slot_cmd_q  [NCORES];
  cmd_e              slot_cmd_d  [NCORES];
  logic [ADDR_W-1:0] slot_addr_q [NCORES];
  logic [ADDR_W-1:0] slot_addr_d [NCORES];
  logic [DATA_W-1:0] slot_data_q [NCORES];
  logic [DATA_W-1:0] slot_data_d [NCORES];
  logic [DATA_W-1:0] rep_data_q  [NCORES];
  logic [DATA_W-1:0] rep_data_d  [NCORES];
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  rep_entry_t        pipe_q [DELAY];
  rep_entry_t        pipe_d [DELAY];
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NCORES-1:0] gnt_onehot;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  cmd_e              g_cmd;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata, g_old, mem_wdata;
  logic              mem_we;
  rep_entry_t        new_entry, last_stage;

  shmem_rr_arbiter #(.NCORES(NCORES)) u_arb (
    .req_i        (slot_full_q),
    .last_grant_i (last_grant_q),
    .grant_o      (gnt_onehot),
    .grant_idx_o  (gnt_idx)
  );

  assign req_ready_o = ~slot_full_q;

  // Granted operation; memory writes land at the end of the grant cycle.
  always_comb begin
    gnt_any   = |gnt_onehot;
    g_cmd     = slot_cmd_q[gnt_idx];
    g_addr    = slot_addr_q[gnt_idx];
    g_wdata   = slot_data_q[gnt_idx];
    g_old     = mem_q[g_addr];
    mem_we    = 1'b0;
    mem_wdata = g_wdata;
    new_entry = '0;
    if (gnt_any) begin
      new_entry.core = CORE_IDX_W'(gnt_idx);
      case (g_cmd)
        CMD_WRITE: mem_we = 1'b1;
`ifdef SPROCKELL_SHMEM_TESTSET_EN
        CMD_TAS: begin
          new_entry.valid = 1'b1;
          if (g_old == '0) begin
            mem_we         = 1'b1;
            mem_wdata      = DATA_W'(1);
            new_entry.data = REP_DATA_W'(1);
          end
        end
`endif
        default: begin
          new_entry.valid = 1'b1;
          new_entry.data  = REP_DATA_W'(g_old);
        end
      endcase
    end
  end

  always_comb begin
    slot_full_d = slot_full_q;
    slot_cmd_d  = slot_cmd_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    for (int i = 0; i < NCORES; i++) begin
      if (gnt_onehot[i]) slot_full_d[i] = 1'b0;
      if (!slot_full_q[i] && req_cmd_i[2*i +: 2] != CMD_NONE) begin
        slot_full_d[i] = 1'b1;
        slot_cmd_d[i]  = cmd_e'(req_cmd_i[2*i +: 2]);
        slot_addr_d[i] = req_addr_i[i*ADDR_W +: ADDR_W];
        slot_data_d[i] = req_data_i[i*DATA_W +: DATA_W];
      end
    end
    last_grant_d = gnt_any ? gnt_idx : last_grant_q;
    pipe_d[0] = new_entry;
    for (int k = 1; k < DELAY; k++) pipe_d[k] = pipe_q[k-1];
  end

  always_comb begin
    rep_valid_o = '0;
    rep_data_o  = '0;
    rep_data_d  = rep_data_q;
    last_stage  = pipe_q[DELAY-1];
    for (int c = 0; c < NCORES; c++) begin
      rep_valid_o[c] = last_stage.valid && (last_stage.core == CORE_IDX_W'(c));
      if (rep_valid_o[c]) rep_data_d[c] = DATA_W'(last_stage.data);
      rep_data_o[c*DATA_W +: DATA_W] = rep_data_d[c];
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      slot_full_q  <= '0;
      last_grant_q <= IDX_W'(NCORES - 1);
      for (int i = 0; i < NCORES; i++) begin
        slot_cmd_q[i]  <= CMD_NONE;
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
        rep_data_q[i]  <= '0;
      end
      for (int k = 0; k < DELAY; k++) pipe_q[k] <= '0;
    end else begin
      slot_full_q  <= slot_full_d;
      last_grant_q <= last_grant_d;
      slot_cmd_q   <= slot_cmd_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      rep_data_q   <= rep_data_d;
      pipe_q       <= pipe_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge system1000) begin
    if (mem_we) mem_q[g_addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_sprockell_shared_mem.sv
// Self-checking bench for sprockell_shared_mem (NCORES=4, DELAY=2).
module tb_sprockell_shared_mem;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DL = 2;
  localparam int NV = 18;

  logic             clk  = 1'b0;
  logic             rstn = 1'b0;
  logic [2*NC-1:0]  cmd;
  logic [AW*NC-1:0] addr;
  logic [DW*NC-1:0] wdata;
  logic [NC-1:0]    ready;
  logic [NC-1:0]    valid;
  logic [DW*NC-1:0] rdata;

  int errors = 0;
  int checks = 0;
  int exp_core;
  int spurious;
  int cnt [NC];
  logic [DW-1:0] exp_tas0, exp_tas_read;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  sprockell_shared_mem #(.NCORES(NC), .ADDR_W(AW), .DATA_W(DW), .DELAY(DL)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .req_cmd_i       (cmd),
    .req_addr_i      (addr),
    .req_data_i      (wdata),
    .req_ready_o     (ready),
    .rep_valid_o     (valid),
    .rep_data_o      (rdata)
  );

  function automatic vec_t mk(input logic [7:0] c, input logic [31:0] a, input logic [63:0] d,
                              input logic [3:0] er, input logic [3:0] ev, input logic [63:0] ed);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = d;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [31:0] a, input logic [63:0] d);
    cmd   = c;
    addr  = a;
    wdata = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive(8'h00, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Core 0: write/ignored write/read-back, negative data, then write-to-read forwarding via cores 1/2.
    vecs[0]  = mk(8'h02, 32'h00000005, 64'h1234, 4'hF, 4'h0, 64'h0);
    vecs[1]  = mk(8'h02, 32'h00000005, 64'h5555, 4'hE, 4'h0, 64'h0);
    vecs[2]  = mk(8'h01, 32'h00000005, 64'h0,    4'hF, 4'h0, 64'h0);
    vecs[3]  = mk(8'h00, 32'h0,        64'h0,    4'hE, 4'h0, 64'h0);
    vecs[4]  = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h0, 64'h0);
    vecs[5]  = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h1, 64'h1234);
    vecs[6]  = mk(8'h02, 32'h00000009, 64'h8000, 4'hF, 4'h0, 64'h1234);
    vecs[7]  = mk(8'h00, 32'h0,        64'h0,    4'hE, 4'h0, 64'h1234);
    vecs[8]  = mk(8'h01, 32'h00000009, 64'h0,    4'hF, 4'h0, 64'h1234);
    vecs[9]  = mk(8'h00, 32'h0,        64'h0,    4'hE, 4'h0, 64'h1234);
    vecs[10] = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h0, 64'h1234);
    vecs[11] = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h1, 64'h8000);
    vecs[12] = mk(8'h18, 32'h00070700, 64'h00000000BEEF0000, 4'hF, 4'h0, 64'h8000);
    vecs[13] = mk(8'h00, 32'h0,        64'h0,    4'h9, 4'h0, 64'h8000);
    vecs[14] = mk(8'h00, 32'h0,        64'h0,    4'hB, 4'h0, 64'h8000);
    vecs[15] = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h0, 64'h8000);
    vecs[16] = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h4, 64'h0000BEEF00008000);
    vecs[17] = mk(8'h00, 32'h0,        64'h0,    4'hF, 4'h0, 64'h0000BEEF00008000);

`ifdef SPROCKELL_SHMEM_TESTSET_EN
    exp_tas0     = 16'h0001;
    exp_tas_read = 16'h0001;
`else
    exp_tas0     = 16'h0000;
    exp_tas_read = 16'h0000;
`endif

    drive(8'h00, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int k = 0; k < NV; k++) begin
      chk($sformatf("vec%0d ready", k), 64'(ready), 64'(vecs[k].exp_ready));
      chk($sformatf("vec%0d valid", k), 64'(valid), 64'(vecs[k].exp_valid));
      chk($sformatf("vec%0d data", k),  64'(rdata), vecs[k].exp_data);
      drive(vecs[k].cmd, vecs[k].addr, vecs[k].wdata);
      @(negedge clk);
    end

    // Contention after reset: mem[7] keeps 0xBEEF, core 1 before core 2.
    do_reset();
    chk("reset ready", 64'(ready), 64'hF);
    chk("reset valid", 64'(valid), 64'h0);
    chk("reset data", 64'(rdata), 64'h0);
    drive(8'h14, 32'h00070700, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    chk("contend ready both", 64'(ready), 64'h9);
    @(negedge clk);
    chk("contend ready core1 freed", 64'(ready), 64'hB);
    @(negedge clk);
    chk("contend valid core1", 64'(valid), 64'h2);
    chk("contend data core1", 64'(rdata[31:16]), 64'hBEEF);
    @(negedge clk);
    chk("contend valid core2", 64'(valid), 64'h4);
    chk("contend data core2", 64'(rdata[47:32]), 64'hBEEF);
    chk("contend hold core1", 64'(rdata[31:16]), 64'hBEEF);
    @(negedge clk);
    chk("contend valid idle", 64'(valid), 64'h0);

    // Test-and-set race on addr 3 (cleared by core 1 first).
    drive(8'h08, 32'h00000300, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    @(negedge clk);
    drive(8'h0F, 32'h00000303, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("tas valid core0", 64'(valid), 64'h1);
    chk("tas data core0", 64'(rdata[15:0]), 64'(exp_tas0));
    @(negedge clk);
    chk("tas valid core1", 64'(valid), 64'h2);
    chk("tas data core1", 64'(rdata[31:16]), 64'h0);
    drive(8'h10, 32'h00030000, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("tas readback valid", 64'(valid), 64'h4);
    chk("tas readback data", 64'(rdata[47:32]), 64'(exp_tas_read));

    // Fairness: all cores read continuously for 40 cycles.
    do_reset();
    exp_core = 0;
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid != '0) begin
        chk($sformatf("fair order reply%0d", i), 64'(valid), 64'(4'b0001 << exp_core));
        for (int c = 0; c < NC; c++) if (valid[c]) cnt[c]++;
        exp_core = (exp_core + 1) % NC;
      end
      drive(8'h55, 32'h09090909, 64'h0);
      @(negedge clk);
    end
    drive(8'h00, 32'h0, 64'h0);
    repeat (8) @(negedge clk);
    for (int c = 0; c < NC; c++)
      chk($sformatf("fair count core%0d in 9..11 (count=%0d)", c, cnt[c]),
          64'(cnt[c] >= 9 && cnt[c] <= 11), 64'h1);

    // Reset one cycle after a read grant: the reply must never appear.
    do_reset();
    drive(8'h40, 32'h09000000, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    @(negedge clk);
    rstn = 1'b0;
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      spurious += $countones(valid);
    end
    rstn = 1'b1;
    chk("midrst ready", 64'(ready), 64'hF);
    chk("midrst data", 64'(rdata), 64'h0);
    repeat (6) begin
      spurious += $countones(valid);
      @(negedge clk);
    end
    chk("midrst no reply", 64'(spurious), 64'h0);
    drive(8'h40, 32'h09000000, 64'h0);
    @(negedge clk);
    drive(8'h00, 32'h0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst mem valid", 64'(valid), 64'h8);
    chk("midrst mem data", 64'(rdata[63:48]), 64'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
